// File: rtl/mul_pkg.sv
// mul_pkg: shared definitions for the shared shift-add multiplier scheduler.
//   - FSM state encoding (IDLE/LOAD/RUN/DONE) as 2-bit constants
//   - default operand width MUL_W and client count NUM_CLIENTS
//   - sched_dbg_t: snapshot of scheduler control state for observation
//   - owner_onehot(): converts an owner index to a one-hot grant vector
package mul_pkg;

  localparam int MUL_W       = 16;
  localparam int NUM_CLIENTS = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef struct packed {
    logic [1:0] state;
    logic       rr;
    logic       owner;
  } sched_dbg_t;

  function automatic logic [NUM_CLIENTS-1:0] owner_onehot(input logic owner);
    owner_onehot = owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// mul_shift_add_dp: iterative shift-add multiplier datapath.
// Holds multiplicand M, multiplier Q, accumulator ACC and step counter.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   ld           load a/b into M/Q, clear ACC, count <= W
//   step         one add/shift step (add M << (W-count) when Q[0])
//   a, b         operands sampled on ld
//   q_zero       Q will be zero after the current step (Q[W-1:1] == 0)
//   cnt_last     current step is the final one of a full-length run
//   acc          accumulator (2W bits)
module mul_shift_add_dp
  import mul_pkg::*;
#(
  parameter int W = MUL_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ld,
  input  logic           step,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           q_zero,
  output logic           cnt_last,
  output logic [2*W-1:0] acc
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]   m_r;
  logic [W-1:0]   q_r;
  logic [2*W-1:0] acc_r;
  logic [CW-1:0]  count_r;

  logic [CW-1:0]  shamt;
  logic [2*W-1:0] addend;

  // Bit position of the current multiplier bit: 0 on the first step, W-1 on the last.
  assign shamt  = CW'(W) - count_r;
  assign addend = {{W{1'b0}}, m_r} << shamt;

  // Looks at the post-shift value so the scheduler can leave RUN at the end of this cycle.
  assign q_zero   = (q_r[W-1:1] == '0);
  assign cnt_last = (count_r == CW'(1));
  assign acc      = acc_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_r     <= '0;
      q_r     <= '0;
      acc_r   <= '0;
      count_r <= '0;
    end else if (ld) begin
      m_r     <= a;
      q_r     <= b;
      acc_r   <= '0;
      count_r <= CW'(W);
    end else if (step) begin
      if (q_r[0]) begin
        acc_r <= acc_r + addend;
      end
      q_r     <= q_r >> 1;
      count_r <= count_r - CW'(1);
    end
  end

endmodule

// File: rtl/mul_share_sched.sv
// mul_share_sched: shares one iterative shift-add multiplier between two
// requesters with round-robin arbitration.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req[1:0]          request levels, held until the client's done
//   a0/b0, a1/b1      per-client operands, sampled in the LOAD cycle
//   gnt[1:0]          one-hot grant, LOAD through DONE
//   busy              scheduler not idle
//   done              one-cycle result pulse
//   done_id           owner of the current/last result
//   product[2W-1:0]   result, valid with done and held until the next one
// Build option: define MUL_SHARE_SCHED_EARLY_EXIT_EN to leave RUN as soon as
// the remaining multiplier bits are all zero.
// Handshake: a client raises req[i] and holds it; a request is only sampled
// while idle; the transaction ends with done=1 and done_id=i for one cycle,
// after which the client may drop or re-raise req[i].
module mul_share_sched
  import mul_pkg::*;
#(
  parameter int W = MUL_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     req,
  input  logic [W-1:0]   a0,
  input  logic [W-1:0]   b0,
  input  logic [W-1:0]   a1,
  input  logic [W-1:0]   b1,
  output logic [1:0]     gnt,
  output logic           busy,
  output logic           done,
  output logic           done_id,
  output logic [2*W-1:0] product
);

  logic [1:0]     state_r;
  logic [1:0]     state_nxt;
  logic           rr_r;
  logic           owner_r;
  logic           pick;
  logic [2*W-1:0] product_r;

  logic           dp_ld;
  logic           dp_step;
  logic           q_zero;
  logic           cnt_last;
  logic [2*W-1:0] acc;
  logic           run_exit;

  sched_dbg_t     unused_dbg;

  // Control snapshot for external checkers; nothing in the design reads it.
  assign unused_dbg = '{state: state_r, rr: rr_r, owner: owner_r};

  assign dp_ld   = (state_r == ST_LOAD);
  assign dp_step = (state_r == ST_RUN);

`ifdef MUL_SHARE_SCHED_EARLY_EXIT_EN
  assign run_exit = cnt_last | q_zero;
`else
  logic unused_q_zero;
  assign unused_q_zero = q_zero;
  assign run_exit      = cnt_last;
`endif

  // Both requesting: rr decides; otherwise whichever single bit is set.
  assign pick = (req == 2'b11) ? rr_r : req[1];

  mul_shift_add_dp #(.W(W)) u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld       (dp_ld),
    .step     (dp_step),
    .a        (owner_r ? a1 : a0),
    .b        (owner_r ? b1 : b0),
    .q_zero   (q_zero),
    .cnt_last (cnt_last),
    .acc      (acc)
  );

  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: if (req != 2'b00) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_RUN;
      ST_RUN:  if (run_exit) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      rr_r      <= 1'b0;
      owner_r   <= 1'b0;
      product_r <= '0;
    end else begin
      state_r <= state_nxt;
      if (state_r == ST_IDLE && req != 2'b00) begin
        owner_r <= pick;
      end
      if (state_r == ST_DONE) begin
        // The client just served yields priority to the other one.
        rr_r      <= ~owner_r;
        product_r <= acc;
      end
    end
  end

  assign busy    = (state_r != ST_IDLE);
  assign done    = (state_r == ST_DONE);
  assign done_id = owner_r;
  assign gnt     = busy ? owner_onehot(owner_r) : 2'b00;
  // Bypass so the result is visible in the same cycle as done.
  assign product = done ? acc : product_r;

endmodule

// File: tb/tb_mul_share_sched.sv
module tb_mul_share_sched;

  localparam int W = 16;

  logic           clk;
  logic           rst_n;
  logic [1:0]     req;
  logic [W-1:0]   a0, b0, a1, b1;
  logic [1:0]     gnt;
  logic           busy;
  logic           done;
  logic           done_id;
  logic [2*W-1:0] product;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int consec   = 0;
  logic done_prev = 1'b0;
  logic rr_m = 1'b0;

  mul_share_sched #(.W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .a0      (a0),
    .b0      (b0),
    .a1      (a1),
    .b1      (b1),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .product (product)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // done pulse monitor
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (done === 1'b1 && done_prev === 1'b1) consec++;
    done_prev = done;
  end

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] x;
    logic [2*W-1:0] y;
    x = {{W{1'b0}}, a};
    y = {{W{1'b0}}, b};
    return x * y;
  endfunction

  function automatic int exp_latency(input logic [W-1:0] b);
`ifdef MUL_SHARE_SCHED_EARLY_EXIT_EN
    int top = 0;
    for (int i = 0; i < W; i++) if (b[i]) top = i + 1;
    return 2 + ((top < 1) ? 1 : top);
`else
    return W + 2;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the done pulse of client id, checks latency, owner,
  // grant and product, drops req[id], then checks the following idle cycle.
  task automatic wait_done(input string tag, input logic id, input logic [2*W-1:0] exp_p,
                           input int exp_lat, input int drop_at, input int pulse_at);
    int cyc = 0;
    logic seen = 1'b0;
    logic [1:0] g_d = 2'b00;
    logic [2*W-1:0] p_d = '0;
    logic id_d = 1'b0;
    while (!seen && cyc < exp_lat + 40) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        seen = 1'b1;
        g_d  = gnt;
        p_d  = product;
        id_d = done_id;
      end
      if (cyc == drop_at) req[id] = 1'b0;
      if (cyc == pulse_at) req[~id] = 1'b1;
      if (cyc == pulse_at + 1) req[~id] = 1'b0;
    end
    check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_id"}, 64'(id_d), 64'(id));
    check({tag, "_gnt"}, 64'(g_d), id ? 64'd2 : 64'd1);
    check({tag, "_prod"}, 64'(p_d), 64'(exp_p));
    req[id] = 1'b0;
    rr_m = ~id;
    @(negedge clk);
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    check({tag, "_hold_prod"}, 64'(product), 64'(exp_p));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, 64'(gnt), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_id"}, 64'(done_id), 64'd0);
    check({tag, "_prod"}, 64'(product), 64'd0);
  endtask

  initial begin
    int d0;
    int pat;
    logic first;
    logic [W-1:0] fa0, fb0, fa1, fb1;

    rst_n = 1'b0;
    req = 2'b00;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    rr_m = 1'b0;
    @(negedge clk);

    // client 0 alone, 2*3
    a0 = 16'd2; b0 = 16'd3; req = 2'b01;
    wait_done("c0_2x3", 1'b0, ref_prod(16'd2, 16'd3), exp_latency(16'd3), -1, -1);

    // both requesting right after reset: client 0 then client 1
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rr_m = 1'b0;
    a0 = 16'd5; b0 = 16'd7; a1 = 16'd9; b1 = 16'd11; req = 2'b11;
    first = rr_m;
    wait_done("both_c0", first, ref_prod(16'd5, 16'd7), exp_latency(16'd7), -1, -1);
    wait_done("both_c1", ~first, ref_prod(16'd9, 16'd11), exp_latency(16'd11), -1, -1);

    // client 1 max operands, client 0 waiting with its own operands
    a0 = 16'($urandom); b0 = 16'($urandom);
    a1 = 16'hFFFF; b1 = 16'hFFFF; req = 2'b10;
    @(negedge clk);
    req[0] = 1'b1;
    wait_done("max_c1", 1'b1, 32'hFFFE0001, exp_latency(16'hFFFF) - 1, -1, -1);
    wait_done("max_then_c0", 1'b0, ref_prod(a0, b0), exp_latency(b0), -1, -1);

    // client 0 re-requests while client 1 waits: client 1 wins
    a0 = 16'($urandom); b0 = 16'($urandom) | 16'h0100;
    a1 = 16'($urandom); b1 = 16'($urandom);
    req = 2'b01;
    @(negedge clk);
    req[1] = 1'b1;
    wait_done("rereq_c0", 1'b0, ref_prod(a0, b0), exp_latency(b0) - 1, -1, -1);
    req[0] = 1'b1;
    first = rr_m;
    wait_done("rereq_other", first, first ? ref_prod(a1, b1) : ref_prod(a0, b0),
              exp_latency(first ? b1 : b0), -1, -1);
    wait_done("rereq_last", ~first, first ? ref_prod(a0, b0) : ref_prod(a1, b1),
              exp_latency(first ? b0 : b1), -1, -1);

    // zero multiplier
    a0 = 16'h1234; b0 = 16'h0000; req = 2'b01;
    wait_done("zero_b", 1'b0, '0, exp_latency(16'h0000), -1, -1);

    // reset mid-RUN
    a0 = 16'($urandom); b0 = 16'($urandom) | 16'h8000; req = 2'b01;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun_rst");
    d0 = done_cnt;
    a1 = 16'($urandom); b1 = 16'($urandom);
    req = 2'b11;
    repeat (3) @(negedge clk);
    check("midrun_no_done", 64'(done_cnt), 64'(d0));
    rst_n = 1'b1;
    rr_m = 1'b0;
    wait_done("post_rst_c0", 1'b0, ref_prod(a0, b0), exp_latency(b0), -1, -1);
    wait_done("post_rst_c1", 1'b1, ref_prod(a1, b1), exp_latency(b1), -1, -1);

    // req0 dropped during RUN: still completes
    a0 = 16'($urandom); b0 = 16'($urandom) | 16'h8000; req = 2'b01;
    wait_done("drop_run", 1'b0, ref_prod(a0, b0), exp_latency(b0), 4, -1);

    // one-cycle req0 pulse while busy: never granted
    a1 = 16'($urandom); b1 = 16'($urandom) | 16'h8000; req = 2'b10;
    wait_done("pulse_c1", 1'b1, ref_prod(a1, b1), exp_latency(b1), -1, 3);
    d0 = done_cnt;
    repeat (6) @(negedge clk);
    check("pulse_no_busy", 64'(busy), 64'd0);
    check("pulse_no_gnt", 64'(gnt), 64'd0);
    check("pulse_no_done", 64'(done_cnt), 64'(d0));

    // randomized transactions
    for (int t = 0; t < 12; t++) begin
      fa0 = 16'($urandom); fb0 = 16'($urandom);
      fa1 = 16'($urandom); fb1 = 16'($urandom);
      if (t % 4 == 1) fb0 = '0;
      if (t % 4 == 2) fa1 = 16'hFFFF;
      a0 = fa0; b0 = fb0; a1 = fa1; b1 = fb1;
      pat = $urandom_range(1, 3);
      req = 2'(pat);
      first = (pat == 3) ? rr_m : (pat == 2);
      wait_done("rand_a", first, first ? ref_prod(fa1, fb1) : ref_prod(fa0, fb0),
                exp_latency(first ? fb1 : fb0), -1, -1);
      if (pat == 3) begin
        wait_done("rand_b", ~first, first ? ref_prod(fa0, fb0) : ref_prod(fa1, fb1),
                  exp_latency(first ? fb0 : fb1), -1, -1);
      end
    end

    check("no_consecutive_done", 64'(consec), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_share_sched.md
Name: mul_share_sched

Overview:
- Scheduler that shares one iterative shift-add multiplier between two requesters.
- Arbitrates round-robin, latches the winner's operands into the datapath, and sequences W add/shift steps.
- Returns the 2W-bit product with a one-cycle done pulse tagged with the owner id.
- Sits between client logic and the multiplier datapath; replaces ad-hoc per-client start/ld sequencing.

Parameters:
- W, 16, operand width in bits; product is 2W bits; W >= 2.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  2  per-client request level; req[i] held until done for client i
- a0  in  W  client 0 multiplicand
- b0  in  W  client 0 multiplier
- a1  in  W  client 1 multiplicand
- b1  in  W  client 1 multiplier
- gnt  out  2  one-hot grant; high from LOAD through DONE
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse, product valid
- done_id  out  1  client index owning the current/last result
- product  out  2W  result; held until next LOAD

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; gnt=0, busy=0, done=0, done_id=0, product=0.
  - Round-robin pointer rr=0 (client 0 preferred); internal M, Q, ACC, count cleared.
- States: IDLE -> LOAD -> RUN -> DONE -> IDLE.
- IDLE:
  - If req==0, stay.
  - If exactly one req bit is set, grant it.
  - If both are set, grant client rr.
  - Register the owner and go to LOAD.
  - Requests are sampled only in IDLE.
- LOAD (1 cycle):
  - gnt[owner]=1.
  - M<=a_owner, Q<=b_owner, ACC<=0, count<=W.
  - Operands need only be stable in this cycle.
- RUN (W cycles):
  - Each cycle: if Q[0], ACC <= ACC + (M zero-extended to 2W, shifted left by W-count).
  - Q <= Q>>1, count <= count-1.
  - Exit to DONE when count reaches 1 at the cycle's end.
  - The adder is 2W bits wide; no overflow is possible.
- DONE (1 cycle):
  - done=1, done_id=owner, product<=ACC (visible in the same cycle as done).
  - rr <= ~owner; next state IDLE; gnt drops on exit.
- Latency: req is sampled high in IDLE at edge t; done is high during the cycle after edge t+W+1, i.e. W+2 cycles. Back-to-back throughput is one result per W+3 cycles.
- Boundary conditions:
  - req dropped before grant: no grant, no done.
  - req dropped during LOAD/RUN: operation completes; done still pulses for that owner.
  - Same client re-requests while the other waits: the other wins (rr flipped in DONE).
  - Operand 0: product=0 after the full W cycles (full-length RUN unless the optional feature is enabled).
  - Max operands 2^W-1 squared: no truncation.
  - rst_n asserted mid-RUN: immediate abort to reset values; no done; the aborted client must re-request.
  - done is never asserted in two consecutive cycles.

Optional Feature:
- MUL_SHARE_SCHED_EARLY_EXIT_EN.
- When defined:
  - RUN exits to DONE at the end of any cycle in which the shifted Q becomes zero, or when count reaches 1.
  - Latency = 2 + max(1, index of the highest set bit of b, plus 1) cycles.
  - b=0 gives one RUN cycle; the product is still exact.
- When undefined: RUN is always exactly W cycles.

Decomposition:
- Shared package mul_pkg:
  - state encoding (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, DONE=2'd3);
  - default width constant MUL_W=16;
  - client-count constant NUM_CLIENTS=2.
- One sub-module, mul_shift_add_dp:
  - holds M, Q, ACC, count;
  - inputs: ld, step;
  - outputs: q_zero, cnt_last, acc.
- The scheduler keeps the FSM, the round-robin pointer, the grant, and product/done registers.

Test Plan:
- Client 0 only, a0=2, b0=3 -> gnt=2'b01 from LOAD to DONE; done after 18 cycles (W=16); done_id=0; product=6.
- Both req in the same IDLE cycle after reset, (a0,b0)=(5,7) and (a1,b1)=(9,11):
  - client 0 first, product=35;
  - then client 1, product=99, done_id=1;
  - exactly one done pulse each.
- Client 1 with a1=b1=16'hFFFF -> product=32'hFFFE0001; client 0 held high throughout is served next with its own operands.
- b0=0, a0=16'h1234 -> product=0:
  - 18-cycle latency without the macro;
  - 3-cycle latency with MUL_SHARE_SCHED_EARLY_EXIT_EN.
- rst_n pulsed low mid-RUN -> all outputs 0 immediately, no done. After release with req=2'b11, client 0 is granted (rr reset).
- req0 dropped during RUN -> done still pulses with the correct product. A req0 pulse lasting one cycle while not in IDLE -> no grant.
